// File: rtl/cu_clock_pkg.sv
// Shared types and 100 MHz timing defaults for the clock's time-setting path.
package cu_clock_pkg;

  localparam int CLK_HZ = 100_000_000;

  // 20 ms debounce, 500 ms hold-to-repeat, 100 ms repeat period
  localparam int DEFAULT_DEBOUNCE_CYC = CLK_HZ / 50;
  localparam int DEFAULT_HOLD_CYC     = CLK_HZ / 2;
  localparam int DEFAULT_REPEAT_CYC   = CLK_HZ / 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_fsm_t;

endpackage

// File: rtl/btn_debounce.sv
// One-bit synchroniser and debouncer; level_o changes after DEBOUNCE_CYC consecutive
// disagreeing samples. Latency raw->level is DEBOUNCE_CYC+2 edges; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             s;

  assign s       = sync_q[1];
  assign level_o = level_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/set_button_ctrl.sv
// Debounced set buttons producing one-cycle increment pulses with hold-to-auto-repeat.
// Press to first pulse is DEBOUNCE_CYC+3 edges; outputs are free-running, no backpressure.
module set_button_ctrl
  import cu_clock_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEFAULT_HOLD_CYC,
  parameter int REPEAT_CYC   = DEFAULT_REPEAT_CYC
) (
  input  logic             cu_clk,
  input  logic             btn_reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             set_en,
  output logic [N_BTN-1:0] inc_pulse,
  output logic [N_BTN-1:0] btn_level
);

  localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REPEAT_LD = TMR_W'(REPEAT_CYC - 1);

  logic [N_BTN-1:0] level_w;

  assign btn_level = level_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_fsm_t         state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             lvl_prev_q;
    logic             pulse_q, pulse_d;
    logic             rise;

    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk_i   (cu_clk),
      .rst_ni  (btn_reset),
      .raw_i   (btn_raw[i]),
      .level_o (level_w[i])
    );

    assign rise         = level_w[i] & ~lvl_prev_q;
    assign inc_pulse[i] = pulse_q;

    // Release and mode-off both win over a timer expiry in the same cycle
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      pulse_d = 1'b0;
      if (!set_en) begin
        state_d = IDLE;
        tmr_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_d = DELAY;
              tmr_d   = HOLD_LD;
              pulse_d = 1'b1;
            end
          end
          DELAY, REPEAT: begin
            if (!level_w[i]) begin
              state_d = IDLE;
              tmr_d   = '0;
            end else if (tmr_q == '0) begin
              state_d = REPEAT;
              tmr_d   = REPEAT_LD;
              pulse_d = 1'b1;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
            tmr_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge cu_clk or negedge btn_reset) begin
      if (!btn_reset) begin
        state_q    <= IDLE;
        tmr_q      <= '0;
        lvl_prev_q <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        tmr_q      <= tmr_d;
        lvl_prev_q <= level_w[i];
        pulse_q    <= pulse_d;
      end
    end
  end

endmodule

// File: tb/tb_set_button_ctrl.sv
// Directed bench for set_button_ctrl with short timing (debounce 4, hold 20, repeat 8).
module tb_set_button_ctrl;

  localparam int N = 2;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic         cu_clk    = 1'b0;
  logic         btn_reset = 1'b0;
  logic [N-1:0] btn_raw   = '0;
  logic         set_en    = 1'b1;
  logic [N-1:0] inc_pulse;
  logic [N-1:0] btn_level;

  always #5 cu_clk = ~cu_clk;

  set_button_ctrl #(
    .N_BTN        (N),
    .DEBOUNCE_CYC (D),
    .HOLD_CYC     (H),
    .REPEAT_CYC   (R)
  ) dut (
    .cu_clk    (cu_clk),
    .btn_reset (btn_reset),
    .btn_raw   (btn_raw),
    .set_en    (set_en),
    .inc_pulse (inc_pulse),
    .btn_level (btn_level)
  );

  // Entry k: inputs applied before edge k, outputs expected just after edge k
  typedef struct {
    logic [1:0] raw;
    logic       en;
    logic [1:0] lvl;
    logic [1:0] pls;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cu_clk);
    #1;
  endtask

  task automatic add(input logic [1:0] raw, input logic en,
                     input logic [1:0] lvl, input logic [1:0] pls);
    vec_t v;
    v.raw = raw;
    v.en  = en;
    v.lvl = lvl;
    v.pls = pls;
    vecs.push_back(v);
  endtask

  task automatic run_table(input string nm);
    foreach (vecs[k]) begin
      btn_raw = vecs[k].raw;
      set_en  = vecs[k].en;
      tick();
      chk($sformatf("%s level @%0d", nm, k), btn_level, vecs[k].lvl);
      chk($sformatf("%s pulse @%0d", nm, k), inc_pulse, vecs[k].pls);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset level", btn_level, 2'b00);
    chk("reset pulse", inc_pulse, 2'b00);
    btn_reset = 1'b1;
    repeat (3) tick();

    // Clean press on bit 0, released after 10 cycles
    for (int k = 0; k < 20; k++)
      add((k < 10) ? 2'b01 : 2'b00, 1'b1,
          (k >= 5 && k < 15) ? 2'b01 : 2'b00,
          (k == 6) ? 2'b01 : 2'b00);
    run_table("press");

    // Bounce: 2-cycle high/low runs never reach the debounce threshold
    for (int k = 0; k < 24; k++)
      add((k < 12 && (k % 4) < 2) ? 2'b01 : 2'b00, 1'b1, 2'b00, 2'b00);
    run_table("bounce");

    // Auto-repeat on bit 1; release lands as the timer expires, so no pulse at 66
    for (int k = 0; k < 75; k++)
      add((k < 60) ? 2'b10 : 2'b00, 1'b1,
          (k >= 5 && k < 65) ? 2'b10 : 2'b00,
          (k == 6 || k == 26 || k == 34 || k == 42 || k == 50 || k == 58) ? 2'b10 : 2'b00);
    run_table("repeat");

    // Both buttons; set_en off 24..29, back on while held, then release and re-press
    for (int k = 0; k < 70; k++)
      add((k < 40 || (k >= 50 && k < 58)) ? 2'b11 : 2'b00,
          (k >= 24 && k < 30) ? 1'b0 : 1'b1,
          ((k >= 5 && k < 45) || (k >= 55 && k < 63)) ? 2'b11 : 2'b00,
          (k == 6 || k == 56) ? 2'b11 : 2'b00);
    run_table("simul");

    // Reset in REPEAT with the button still held
    btn_raw = 2'b01;
    set_en  = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      tick();
      chk($sformatf("pre-reset pulse @%0d", k), inc_pulse,
          (k == 6 || k == 26 || k == 34) ? 2'b01 : 2'b00);
    end
    #2 btn_reset = 1'b0;
    #1;
    chk("async reset level", btn_level, 2'b00);
    chk("async reset pulse", inc_pulse, 2'b00);
    repeat (2) tick();
    chk("held reset level", btn_level, 2'b00);
    chk("held reset pulse", inc_pulse, 2'b00);
    btn_reset = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("post-reset level @%0d", j), btn_level, (j >= 6) ? 2'b01 : 2'b00);
      chk($sformatf("post-reset pulse @%0d", j), inc_pulse, (j == 7) ? 2'b01 : 2'b00);
    end
    btn_raw = 2'b00;
    repeat (10) tick();
    chk("final level", btn_level, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/set_button_ctrl.md
Name: set_button_ctrl

Overview:
- Upstream input stage for the clock's time-setting path.
- Takes raw, bouncy push-button inputs from the Cu IO shield.
- Synchronises and debounces each input, then produces single-cycle increment pulses with hold-to-auto-repeat.
- Pulses drive the hour/minute advance inputs of time_counter; the debounced levels are also exposed for LED feedback.

Parameters:
- N_BTN, 2, number of independent buttons (bit 0 = minute advance, bit 1 = hour advance)
- DEBOUNCE_CYC, 2_000_000, consecutive stable samples needed to accept a level change (20 ms at 100 MHz); must be ≥1
- HOLD_CYC, 50_000_000, cycles from first pulse to first auto-repeat pulse (500 ms)
- REPEAT_CYC, 10_000_000, cycles between subsequent auto-repeat pulses (100 ms); must be ≥2

Ports:
- cu_clk  input  1  system clock, 100 MHz
- btn_reset  input  1  asynchronous, active-low reset
- btn_raw  input  N_BTN  raw button pins, active-high, asynchronous to cu_clk
- set_en  input  1  time-set mode enable (from a DIP switch); when low, no pulses are produced
- inc_pulse  output  N_BTN  one-cycle increment strobe per button, registered
- btn_level  output  N_BTN  debounced button level, registered

Behaviour:
- Reset (btn_reset low, asynchronous) clears all of the following to 0: sync flops, debounce counters, btn_level, inc_pulse and repeat timers. All FSMs go to IDLE.
- Synchronisation: two-flop synchroniser per bit. The sync output is called s.
- Debounce, per bit:
  - The counter increments on every cycle where s != btn_level.
  - The counter clears on any cycle where s == btn_level.
  - When the counter reaches DEBOUNCE_CYC-1 with s still != btn_level, btn_level toggles on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYC samples produces no change.
- Press latency: if btn_raw rises before edge 0 and stays high:
  - btn_level is 1 from edge DEBOUNCE_CYC+1.
  - inc_pulse is high exactly between edge DEBOUNCE_CYC+2 and edge DEBOUNCE_CYC+3.
- Release latency: same as press. btn_level falls at edge DEBOUNCE_CYC+1 after the raw falling edge.
- Repeat FSM, per bit. States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on a rising edge of btn_level while set_en=1. Emit one pulse and load the timer with HOLD_CYC-1.
  - DELAY: timer decrements each cycle. At 0: emit a pulse, load REPEAT_CYC-1, go to REPEAT.
  - REPEAT: at timer 0, emit a pulse and reload REPEAT_CYC-1.
  - DELAY/REPEAT -> IDLE when btn_level=0. No pulse is emitted on the release cycle, even if the timer expires in the same cycle.
  - Any state -> IDLE when set_en=0. No pulses are emitted.
- Resulting pulse spacing: the first repeat pulse comes exactly HOLD_CYC cycles after the press pulse; later pulses come every REPEAT_CYC cycles.
- set_en rising while a button is already held: no pulse. The FSM needs a fresh btn_level rising edge, i.e. release and re-press.
- Buttons are fully independent. Simultaneous pulses on multiple bits are allowed in the same cycle. There is no priority or interlock.
- Button held through reset: after btn_reset deasserts, it is treated as a new press. With set_en=1, inc_pulse fires DEBOUNCE_CYC+3 edges after the release of reset.
- Debouncing continues while set_en=0, so btn_level stays accurate.

Decomposition:
- Shared package cu_clock_pkg holds:
  - the btn_fsm_t enum {IDLE, DELAY, REPEAT};
  - default cycle constants for 100 MHz (DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
  - CLK_HZ = 100_000_000.
- Sub-module btn_debounce handles one bit: synchroniser, debounce counter and btn_level register, with DEBOUNCE_CYC as a parameter.
- set_button_ctrl instantiates btn_debounce N_BTN times via generate and holds the per-bit repeat FSMs and timers.

Test Plan (sim params: DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8, N_BTN=2):
- Clean press: btn_raw[0] 0->1 before edge 0 and held 10 cycles with set_en=1 -> btn_level[0]=1 at edge 5; exactly one inc_pulse[0] between edges 6 and 7; no pulse on bit 1.
- Bounce: btn_raw[0] toggles every 2 cycles for 12 cycles, then stays 0 -> btn_level[0] stays 0 and inc_pulse is never asserted.
- Auto-repeat: hold btn_raw[1] for 60 cycles -> pulses at edges 6, 26, 34, 42, 50, 58; release; no further pulses; btn_level[1] falls 5 edges after release.
- Simultaneous and mode: press both buttons on the same cycle -> both bits pulse at the same edge. Drop set_en mid-hold -> pulses stop immediately. Raise set_en while still held -> no pulse until release and re-press.
- Reset mid-operation: assert btn_reset during REPEAT -> all outputs are 0 immediately (asynchronous). With the button still held, deassert reset -> single pulse 7 edges later.
